// File: rtl/link_rx_pkg.sv
// Shared definitions for the board-to-board link receiver.
// Holds the framing FSM state type and the link constants that the
// transmitter side also uses.
package link_rx_pkg;

  typedef enum logic {HUNT, LOCKED} link_rx_state_t;

  localparam int unsigned LINK_FRAME_BITS    = 49;
  localparam int unsigned LINK_LANES_DEFAULT = 1;

endpackage

// File: rtl/link_rx_deser.sv
// Deserialiser for the link receiver: LANES-wide shift register plus a
// saturating beat counter.
// Ports:
//   clk_i    - link clock
//   rstn_i   - synchronous active-low reset
//   s_in_i   - serial beat, s_in_i[LANES-1] is the earliest bit
//   sync_i   - high on the final beat of a frame (clears the counter)
//   frame_o  - candidate frame {shift register, s_in_i}, first bit at MSB
//   cnt_o    - beats seen since the last sync, saturating at BEATS
module link_rx_deser #(
  parameter int unsigned FRAME_BITS = 49,
  parameter int unsigned LANES      = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rstn_i,
  input  logic [LANES-1:0]                        s_in_i,
  input  logic                                    sync_i,
  output logic [FRAME_BITS-1:0]                   frame_o,
  output logic [$clog2(FRAME_BITS/LANES+1)-1:0]   cnt_o
);

  localparam int unsigned BEATS = FRAME_BITS / LANES;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam int unsigned SH_W  = FRAME_BITS - LANES;
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  logic [CW-1:0] cnt_q, cnt_d;

  // With one beat per frame there is nothing to hold between beats.
  if (SH_W > 0) begin : g_shift
    logic [SH_W-1:0] shreg_q, shreg_d;

    always_comb begin
      frame_o = {shreg_q, s_in_i};
      shreg_d = frame_o[SH_W-1:0];
    end

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        shreg_q <= '0;
      end else begin
        shreg_q <= shreg_d;
      end
    end
  end else begin : g_pass
    always_comb begin
      frame_o = s_in_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = '0;
    end else if (cnt_q != BEATS_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/link_frame_receiver.sv
// Serial-link frame receiver (slave side of the board-to-board link).
// Deserialises LANES bits per clock into FRAME_BITS-wide frames delimited
// by SYNC on the last beat, checks length and optional even parity, and
// hands good frames to the consumer through a one-entry valid/ready buffer.
// Ports:
//   LINK_CLK   - clock
//   RESETN     - synchronous active-low reset
//   S_IN       - serial data, S_IN[LANES-1] earliest bit of the beat
//   SYNC       - high on the final beat of each frame
//   RECV_READY - consumer takes DATA_OUT this cycle
//   DATA_OUT   - held frame, first received bit at the MSB
//   RECV_OK    - DATA_OUT valid until the cycle after a handshake
//   FRAME_ERR  - one-cycle pulse on a length or parity error
//   OVERRUN    - one-cycle pulse when a good frame is dropped (buffer full)
module link_frame_receiver
  import link_rx_pkg::*;
#(
  parameter int unsigned FRAME_BITS = LINK_FRAME_BITS,
  parameter int unsigned LANES      = LINK_LANES_DEFAULT,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic                  LINK_CLK,
  input  logic                  RESETN,
  input  logic [LANES-1:0]      S_IN,
  input  logic                  SYNC,
  input  logic                  RECV_READY,
  output logic [FRAME_BITS-1:0] DATA_OUT,
  output logic                  RECV_OK,
  output logic                  FRAME_ERR,
  output logic                  OVERRUN
);

  localparam int unsigned BEATS = FRAME_BITS / LANES;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [FRAME_BITS-1:0] frame;
  logic [CW-1:0]         cnt;

  link_rx_state_t        state_q, state_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  recv_ok_q, recv_ok_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic par_ok;
  logic good;
  logic load;

  link_rx_deser #(
    .FRAME_BITS (FRAME_BITS),
    .LANES      (LANES)
  ) u_deser (
    .clk_i   (LINK_CLK),
    .rstn_i  (RESETN),
    .s_in_i  (S_IN),
    .sync_i  (SYNC),
    .frame_o (frame),
    .cnt_o   (cnt)
  );

  always_comb begin
    par_ok      = (PARITY_EN == 0) ? 1'b1 : ~(^frame);
    state_d     = state_q;
    good        = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      HUNT: begin
        // The frame that reveals the boundary is never delivered.
        if (SYNC) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (SYNC) begin
          if (cnt == LAST_BEAT) begin
            if (par_ok) begin
              good = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (cnt == LAST_BEAT) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // A handshake in the same cycle frees the buffer for the new frame.
    load      = good && (!recv_ok_q || RECV_READY);
    overrun_d = good && !load;
    data_d    = load ? frame : data_q;

    recv_ok_d = recv_ok_q;
    if (load) begin
      recv_ok_d = 1'b1;
    end else if (RECV_READY && recv_ok_q) begin
      recv_ok_d = 1'b0;
    end
  end

  always_ff @(posedge LINK_CLK) begin
    if (!RESETN) begin
      state_q     <= HUNT;
      data_q      <= '0;
      recv_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      recv_ok_q   <= recv_ok_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign RECV_OK   = recv_ok_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_link_frame_receiver.sv
module tb_link_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // LANES=1 instance
  logic [0:0]  s1;
  logic        sync1, rdy1;
  logic [48:0] d1;
  logic        ok1, err1, ovr1;

  // LANES=7 instance
  logic [6:0]  s7;
  logic        sync7, rdy7;
  logic [48:0] d7;
  logic        ok7, err7, ovr7;

  // LANES=49 instance (one beat per frame)
  logic [48:0] s49;
  logic        sync49, rdy49;
  logic [48:0] d49;
  logic        ok49, err49, ovr49;

  link_frame_receiver #(.FRAME_BITS(49), .LANES(1), .PARITY_EN(1)) dut1 (
    .LINK_CLK(clk), .RESETN(rstn), .S_IN(s1), .SYNC(sync1), .RECV_READY(rdy1),
    .DATA_OUT(d1), .RECV_OK(ok1), .FRAME_ERR(err1), .OVERRUN(ovr1));

  link_frame_receiver #(.FRAME_BITS(49), .LANES(7), .PARITY_EN(1)) dut7 (
    .LINK_CLK(clk), .RESETN(rstn), .S_IN(s7), .SYNC(sync7), .RECV_READY(rdy7),
    .DATA_OUT(d7), .RECV_OK(ok7), .FRAME_ERR(err7), .OVERRUN(ovr7));

  link_frame_receiver #(.FRAME_BITS(49), .LANES(49), .PARITY_EN(1)) dut49 (
    .LINK_CLK(clk), .RESETN(rstn), .S_IN(s49), .SYNC(sync49), .RECV_READY(rdy49),
    .DATA_OUT(d49), .RECV_OK(ok49), .FRAME_ERR(err49), .OVERRUN(ovr49));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [48:0] act, input logic [48:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    int          nb;       // beats sent; SYNC on the last one
    logic        rst;      // reset before this record
    logic        rdy;      // RECV_READY on all but the last beat
    logic        rdy_last; // RECV_READY on the last beat
    logic [48:0] data;     // bits data[nb-1:0] sent MSB first
    logic        eok, eerr, eovr;
    logic [48:0] edata;
  } rec_t;

  rec_t tbl[13];

  task automatic beat1(input logic b, input logic s, input logic r);
    @(negedge clk);
    s1[0] = b; sync1 = s; rdy1 = r;
    @(posedge clk); #1;
  endtask

  task automatic beat7(input logic [6:0] v, input logic s, input logic r);
    @(negedge clk);
    s7 = v; sync7 = s; rdy7 = r;
    @(posedge clk); #1;
  endtask

  task automatic beat49(input logic [48:0] v, input logic s, input logic r);
    @(negedge clk);
    s49 = v; sync49 = s; rdy49 = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; sync1 = 1'b0; sync7 = 1'b0; sync49 = 1'b0;
    @(posedge clk); #1;
    chk("rst_d1", d1, '0);
    chk("rst_ok1", {48'b0, ok1}, '0);
    chk("rst_err1", {48'b0, err1}, '0);
    chk("rst_ovr1", {48'b0, ovr1}, '0);
    chk("rst_d7", d7, '0);
    chk("rst_ok49", {48'b0, ok49}, '0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_rec(input int idx, input rec_t t);
    if (t.rst) do_reset();
    for (int b = 0; b < t.nb; b++) begin
      beat1(t.data[t.nb-1-b], (b == t.nb-1), (b == t.nb-1) ? t.rdy_last : t.rdy);
    end
    chk($sformatf("rec%0d_ok", idx),   {48'b0, ok1},  {48'b0, t.eok});
    chk($sformatf("rec%0d_err", idx),  {48'b0, err1}, {48'b0, t.eerr});
    chk($sformatf("rec%0d_ovr", idx),  {48'b0, ovr1}, {48'b0, t.eovr});
    chk($sformatf("rec%0d_data", idx), d1, t.edata);
  endtask

  task automatic send7(input logic [48:0] x, input logic r);
    for (int k = 0; k < 7; k++) begin
      beat7(x[48-7*k -: 7], (k == 6), r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [48:0] x1, x2;
    int pulses, first;

    rstn = 1'b0;
    s1 = '0; sync1 = 1'b0; rdy1 = 1'b0;
    s7 = '0; sync7 = 1'b0; rdy7 = 1'b0;
    s49 = '0; sync49 = 1'b0; rdy49 = 1'b0;

    //          nb  rst  rdy  rl    data       ok   err  ovr   edata
    tbl[0]  = '{49, 1'b1, 1'b1, 1'b1, 49'h0,  1'b0, 1'b0, 1'b0, 49'h0};  // lock-in, discarded
    tbl[1]  = '{49, 1'b0, 1'b1, 1'b1, 49'h3,  1'b1, 1'b0, 1'b0, 49'h3};  // first delivery
    tbl[2]  = '{49, 1'b0, 1'b1, 1'b1, 49'h1,  1'b0, 1'b1, 1'b0, 49'h3};  // parity error
    tbl[3]  = '{49, 1'b0, 1'b1, 1'b1, 49'h5,  1'b1, 1'b0, 1'b0, 49'h5};
    tbl[4]  = '{30, 1'b0, 1'b1, 1'b1, 49'h0,  1'b0, 1'b1, 1'b0, 49'h5};  // short frame
    tbl[5]  = '{49, 1'b0, 1'b1, 1'b1, 49'hF,  1'b1, 1'b0, 1'b0, 49'hF};  // still locked
    tbl[6]  = '{49, 1'b0, 1'b1, 1'b1, 49'h3,  1'b0, 1'b0, 1'b0, 49'hF};  // after missing sync: discarded
    tbl[7]  = '{49, 1'b0, 1'b1, 1'b1, 49'h6,  1'b1, 1'b0, 1'b0, 49'h6};
    tbl[8]  = '{49, 1'b1, 1'b1, 1'b1, 49'h0,  1'b0, 1'b0, 1'b0, 49'h0};  // reset + lock-in
    tbl[9]  = '{49, 1'b0, 1'b0, 1'b0, 49'h11, 1'b1, 1'b0, 1'b0, 49'h11}; // A held
    tbl[10] = '{49, 1'b0, 1'b0, 1'b0, 49'h12, 1'b1, 1'b0, 1'b1, 49'h11}; // B overrun
    tbl[11] = '{49, 1'b0, 1'b0, 1'b1, 49'h14, 1'b1, 1'b0, 1'b0, 49'h14}; // C with same-cycle ready
    tbl[12] = '{49, 1'b0, 1'b1, 1'b1, 49'h18, 1'b1, 1'b0, 1'b0, 49'h18};

    for (int i = 0; i <= 5; i++) run_rec(i, tbl[i]);

    // Missing sync: 60 beats without SYNC, error only after beat 49.
    pulses = 0; first = 0;
    for (int k = 1; k <= 60; k++) begin
      beat1(1'b0, 1'b0, 1'b1);
      if (err1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("miss_pulses", 49'(pulses), 49'd1);
    chk("miss_pos", 49'(first), 49'd49);

    for (int i = 6; i <= 12; i++) run_rec(i, tbl[i]);

    // Wide lanes: bit order and mid-frame reset.
    x1 = 49'h1_0000_0000_0001;
    x2 = 49'h0_F0F0_0000_00F0;
    do_reset();
    send7(49'h0, 1'b1);
    chk("l7_dummy_ok", {48'b0, ok7}, '0);
    chk("l7_dummy_err", {48'b0, err7}, '0);
    send7(x1, 1'b1);
    chk("l7_x1_ok", {48'b0, ok7}, 49'd1);
    chk("l7_x1_data", d7, x1);
    send7(x2, 1'b1);
    chk("l7_x2_data", d7, x2);
    for (int k = 0; k < 3; k++) beat7(7'h55, 1'b0, 1'b0);
    chk("l7_hold_ok", {48'b0, ok7}, 49'd1);
    chk("l7_hold_data", d7, x2);
    @(negedge clk);
    rstn = 1'b0; s7 = 7'h7F;
    @(posedge clk); #1;
    chk("l7_rst_data", d7, '0);
    chk("l7_rst_ok", {48'b0, ok7}, '0);
    chk("l7_rst_err", {48'b0, err7}, '0);
    chk("l7_rst_ovr", {48'b0, ovr7}, '0);
    @(negedge clk);
    rstn = 1'b1;
    send7(x1, 1'b1);
    chk("l7_hunt_ok", {48'b0, ok7}, '0);
    send7(x2, 1'b1);
    chk("l7_relock_ok", {48'b0, ok7}, 49'd1);
    chk("l7_relock_data", d7, x2);

    // One beat per frame.
    beat49(49'h0, 1'b1, 1'b1);
    chk("l49_lock_ok", {48'b0, ok49}, '0);
    beat49(49'h3, 1'b1, 1'b1);
    chk("l49_ok", {48'b0, ok49}, 49'd1);
    chk("l49_data", d49, 49'h3);
    beat49(49'h1, 1'b1, 1'b1);
    chk("l49_par_err", {48'b0, err49}, 49'd1);
    chk("l49_par_ok", {48'b0, ok49}, '0);
    beat49(49'h5, 1'b0, 1'b1);
    chk("l49_miss_err", {48'b0, err49}, 49'd1);
    beat49(49'h5, 1'b1, 1'b1);
    chk("l49_hunt_ok", {48'b0, ok49}, '0);
    chk("l49_hunt_err", {48'b0, err49}, '0);
    beat49(49'h6, 1'b1, 1'b1);
    chk("l49_relock_data", d49, 49'h6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
